decode_stage: RTL and testbench
===============================

# decode_stage

Pipeline decode stage for the RV64 core: accepts fetched instructions over a valid/ready handshake and decodes the integer ALU subset into an `alufunc_t` operation. It reads the register file and selects operands (register or immediate) so the execute-stage ALU sees final `rd1`/`rd2` values. It registers the decoded bundle toward execute through a two-entry skid buffer. It is the producer side of the ALU operand/opcode interface and sits between fetch and execute.

## Interface
Parameters: none (widths fixed by the `common` package: `u64`, `u32`, `u5`).

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  fetch offers an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_instr`  in  32  raw instruction
- `in_pc`  in  64  instruction PC
- `ra1`, `ra2`  out  5  regfile read addresses, combinational from `in_instr[19:15]`, `[24:20]`
- `rf_rd1`, `rf_rd2`  in  64  regfile read data, combinational, same cycle
- `flush`  in  1  squash all held instructions
- `out_valid`  out  1  decoded bundle valid
- `out_ready`  in  1  execute accepts the bundle
- `out_aluop`  out  `alufunc_t`  ALU operation
- `out_srca`, `out_srcb`  out  64  final ALU operands
- `out_dst`  out  5  destination register
- `out_wen`  out  1  writeback enable
- `out_illegal`  out  1  opcode/funct not supported
- `out_pc`  out  64  PC of the bundle

## Operation
- Decode by opcode:
  - 0110011 (OP): f3=000/f7=0000000 → ADD; f3=000/f7=0100000 → SUB; 111 → AND; 110 → OR; 100 → XOR.
  - 0010011 (OP-IMM): 000 → ADD; 100 → XOR; 110 → OR; 111 → AND; srcb=imm.
  - 0111011 (OP-32): f7=0 → ADDW; f7=0100000 → SUBW.
  - 0011011 (OP-IMM-32): f3=000 → ADDIW, srcb=imm.
  - 0110111 (LUI): ADD, srca=0, srcb=sext({instr[31:12],12'b0}).
- I-immediate: `instr[31:20]` sign-extended to 64 bits. No other immediate formats.
- Any other encoding: `out_illegal`=1, aluop=ALU_ADD, srca=srcb=0, wen=0.
- `out_wen` = legal && rd≠0.
- Buffer: main register (drives outputs) plus skid register.
  - `in_ready` = !skid_valid. It is registered-state only, with no combinational path from `out_ready`.
  - On accept: if main is empty or draining, load main; otherwise load skid.
  - When main drains and skid is full, skid moves to main.
  - Order is strictly FIFO. No loss, no duplication.
- `flush`: at the next edge both entries are invalidated. An `in_valid`&&`in_ready` in the flush cycle is discarded.

## Timing
- Latency: accepted at edge N → `out_valid` and bundle visible after edge N (one cycle).
- Throughput: 1/cycle when `out_ready` is held high.
- Output bundle is stable while `out_valid`&&!`out_ready`.
- Reset (async assert, `reset`=0): `out_valid`=0, skid empty, all registered outputs 0 (aluop=ALU_ADD encoding 0). `in_ready`=1 during and after reset.
- Reset release is synchronous to `clk`. A reset asserted mid-stream drops all held bundles immediately.
- Simultaneous flush and `out_ready`: the flush wins; nothing is presented after the edge.
- Both entries full with `out_ready`=0: `in_ready`=0 until main drains.

## Structure
- `pipes` package: existing `alufunc_t`; add `decode_bundle_t` struct (aluop, srca, srcb, dst, wen, illegal, pc) and opcode/funct constants (`OP_REG`, `OP_IMM`, `OP_REG32`, `OP_IMM32`, `OP_LUI`, `F7_SUB`).
- Sub-module `decoder`: purely combinational. Takes instr, pc, rd1, rd2 and produces a `decode_bundle_t`.
- `decode_stage` holds the two bundle registers and the handshake logic.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rf_rd1=5, rf_rd2=7 → next cycle out_valid=1, ALU_ADD, srca=5, srcb=7, dst=3, wen=1, illegal=0.
- ADDIW x5,x5,-1 (0xFFF2829B), rf_rd1=0x1 → ALU_ADDIW, srca=1, srcb=0xFFFF_FFFF_FFFF_FFFF, dst=5.
- LUI x1,0x80000 (0x800000B7) → ALU_ADD, srca=0, srcb=0xFFFF_FFFF_8000_0000, wen=1. FENCE (0x0000000F) → illegal=1, wen=0.
- Backpressure: issue three back-to-back instrs with out_ready=0 for 4 cycles → in_ready falls after the second accept, the first bundle is held stable, and after release the outputs appear in order 1,2,3 with no duplicates.
- Flush with main and skid full → next cycle out_valid=0, in_ready=1. The instr offered in the flush cycle never appears.
- Assert reset low mid-stream with both entries full → out_valid=0 immediately (asynchronous), in_ready=1. After release, first accept appears one cycle later.

Source files
------------

// File: rtl/common.sv
// Shared fixed-width scalar types for the RV64 core.
package common;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef logic [4:0]  u5;
endpackage

// File: rtl/pipes.sv
// Pipeline types between decode and execute: ALU op encoding, decoded bundle, opcode constants.
package pipes;
  import common::*;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_ADDW  = 4'd5,
    ALU_SUBW  = 4'd6,
    ALU_ADDIW = 4'd7
  } alufunc_t;

  typedef struct packed {
    alufunc_t aluop;
    u64       srca;
    u64       srcb;
    u5        dst;
    logic     wen;
    logic     illegal;
    u64       pc;
  } decode_bundle_t;

  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG32 = 7'b0111011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] F7_SUB   = 7'b0100000;
  localparam logic [6:0] F7_ZERO  = 7'b0000000;
endpackage

// File: rtl/decoder.sv
// Combinational decode of the integer ALU subset into final operands and op.
// Zero latency; no state, so no backpressure.
module decoder
  import common::*;
  import pipes::*;
(
  input  u32             i_instr,
  input  u64             i_pc,
  input  u64             i_rd1,
  input  u64             i_rd2,
  output decode_bundle_t o_bundle
);

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  u64         w_imm_i;
  u64         w_imm_u;
  logic       w_legal;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_imm_i  = {{52{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_u  = {{32{i_instr[31]}}, i_instr[31:12], 12'b0};

  always_comb begin
    w_legal          = 1'b1;
    o_bundle.aluop   = ALU_ADD;
    o_bundle.srca    = i_rd1;
    o_bundle.srcb    = i_rd2;
    o_bundle.dst     = i_instr[11:7];
    o_bundle.wen     = 1'b0;
    o_bundle.illegal = 1'b0;
    o_bundle.pc      = i_pc;

    case (w_opcode)
      OP_REG: begin
        if (w_f3 == 3'b000 && w_f7 == F7_SUB)            o_bundle.aluop = ALU_SUB;
        else if (w_f7 != F7_ZERO)                        w_legal = 1'b0;
        else if (w_f3 == 3'b000)                         o_bundle.aluop = ALU_ADD;
        else if (w_f3 == 3'b111)                         o_bundle.aluop = ALU_AND;
        else if (w_f3 == 3'b110)                         o_bundle.aluop = ALU_OR;
        else if (w_f3 == 3'b100)                         o_bundle.aluop = ALU_XOR;
        else                                             w_legal = 1'b0;
      end
      OP_IMM: begin
        o_bundle.srcb = w_imm_i;
        case (w_f3)
          3'b000:  o_bundle.aluop = ALU_ADD;
          3'b100:  o_bundle.aluop = ALU_XOR;
          3'b110:  o_bundle.aluop = ALU_OR;
          3'b111:  o_bundle.aluop = ALU_AND;
          default: w_legal = 1'b0;
        endcase
      end
      OP_REG32: begin
        if (w_f3 == 3'b000 && w_f7 == F7_ZERO)      o_bundle.aluop = ALU_ADDW;
        else if (w_f3 == 3'b000 && w_f7 == F7_SUB)  o_bundle.aluop = ALU_SUBW;
        else                                        w_legal = 1'b0;
      end
      OP_IMM32: begin
        o_bundle.srcb = w_imm_i;
        if (w_f3 == 3'b000) o_bundle.aluop = ALU_ADDIW;
        else                w_legal = 1'b0;
      end
      OP_LUI: begin
        o_bundle.srca = '0;
        o_bundle.srcb = w_imm_u;
      end
      default: w_legal = 1'b0;
    endcase

    // Illegal encodings present a harmless ADD 0+0 that never writes back.
    if (!w_legal) begin
      o_bundle.aluop   = ALU_ADD;
      o_bundle.srca    = '0;
      o_bundle.srcb    = '0;
      o_bundle.illegal = 1'b1;
    end
    o_bundle.wen = w_legal && (o_bundle.dst != 5'd0);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: regfile read, operand select, two-entry skid buffer toward execute.
// One-cycle latency; in_ready depends only on skid occupancy, never on out_ready.
module decode_stage
  import common::*;
  import pipes::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     in_valid,
  output logic     in_ready,
  input  u32       in_instr,
  input  u64       in_pc,
  output u5        ra1,
  output u5        ra2,
  input  u64       rf_rd1,
  input  u64       rf_rd2,
  input  logic     flush,
  output logic     out_valid,
  input  logic     out_ready,
  output alufunc_t out_aluop,
  output u64       out_srca,
  output u64       out_srcb,
  output u5        out_dst,
  output logic     out_wen,
  output logic     out_illegal,
  output u64       out_pc
);

  decode_bundle_t w_bundle;
  decode_bundle_t r_main;
  decode_bundle_t r_skid;
  logic           r_main_vld;
  logic           r_skid_vld;
  logic           w_accept;
  logic           w_main_free;

  assign ra1 = in_instr[19:15];
  assign ra2 = in_instr[24:20];

  decoder u_decoder (
    .i_instr  (in_instr),
    .i_pc     (in_pc),
    .i_rd1    (rf_rd1),
    .i_rd2    (rf_rd2),
    .o_bundle (w_bundle)
  );

  assign in_ready    = !r_skid_vld;
  assign w_accept    = in_valid && in_ready;
  assign w_main_free = !r_main_vld || out_ready;

  // Skid is only ever full when input is blocked, so skid->main and a new
  // accept into main never compete.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_vld) begin
        r_main     <= r_skid;
        r_main_vld <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (w_accept) begin
        r_main     <= w_bundle;
        r_main_vld <= 1'b1;
      end else begin
        r_main_vld <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid     <= w_bundle;
      r_skid_vld <= 1'b1;
    end
  end

  assign out_valid   = r_main_vld;
  assign out_aluop   = r_main.aluop;
  assign out_srca    = r_main.srca;
  assign out_srcb    = r_main.srcb;
  assign out_dst     = r_main.dst;
  assign out_wen     = r_main.wen;
  assign out_illegal = r_main.illegal;
  assign out_pc      = r_main.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, backpressure, flush, async reset.
module tb_decode_stage;
  import common::*;
  import pipes::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     in_valid;
  logic     in_ready;
  u32       in_instr;
  u64       in_pc;
  u5        ra1, ra2;
  u64       rf_rd1, rf_rd2;
  logic     flush;
  logic     out_valid;
  logic     out_ready;
  alufunc_t out_aluop;
  u64       out_srca, out_srcb;
  u5        out_dst;
  logic     out_wen, out_illegal;
  u64       out_pc;

  u64 regs [32];
  int n_tests = 0;
  int n_fail  = 0;

  assign rf_rd1 = regs[ra1];
  assign rf_rd2 = regs[ra2];

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
    .out_srca(out_srca), .out_srcb(out_srcb), .out_dst(out_dst),
    .out_wen(out_wen), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic chk_bundle(input string tag, input alufunc_t op, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] dst, input logic wen,
                            input logic ill, input logic [63:0] pc);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".aluop"}, 64'(out_aluop), 64'(op));
    chk({tag, ".srca"},  out_srca, a);
    chk({tag, ".srcb"},  out_srcb, b);
    chk({tag, ".dst"},   64'(out_dst), 64'(dst));
    chk({tag, ".wen"},   64'(out_wen), 64'(wen));
    chk({tag, ".ill"},   64'(out_illegal), 64'(ill));
    chk({tag, ".pc"},    out_pc, pc);
  endtask

  // Single instruction through an unstalled stage, then the stage must empty.
  task automatic one(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                     input alufunc_t op, input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] dst, input logic wen, input logic ill);
    offer(instr, pc);
    tick();
    in_valid = 1'b0;
    chk_bundle(tag, op, a, b, dst, wen, ill, pc);
    tick();
    chk({tag, ".drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 64'(i) * 64'h10;
    regs[0] = '0;
    regs[1] = 64'd5;
    regs[2] = 64'd7;
    regs[5] = 64'd1;

    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.aluop", 64'(out_aluop), 64'd0);
    chk("rst.srca", out_srca, 64'd0);
    chk("rst.pc", out_pc, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst.in_ready", 64'(in_ready), 64'd1);

    one("add",   32'h002081B3, 64'h1000, ALU_ADD,   64'd5, 64'd7, 5'd3, 1'b1, 1'b0);
    one("addiw", 32'hFFF2829B, 64'h1004, ALU_ADDIW, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 1'b1, 1'b0);
    one("lui",   32'h800000B7, 64'h1008, ALU_ADD,   64'd0, 64'hFFFF_FFFF_8000_0000, 5'd1, 1'b1, 1'b0);
    one("lui_rs", 32'h800080B7, 64'h100C, ALU_ADD,  64'd0, 64'hFFFF_FFFF_8000_8000, 5'd1, 1'b1, 1'b0);
    one("fence", 32'h0000000F, 64'h1010, ALU_ADD,   64'd0, 64'd0, 5'd0, 1'b0, 1'b1);
    one("sub",   32'h40208233, 64'h1014, ALU_SUB,   64'd5, 64'd7, 5'd4, 1'b1, 1'b0);
    one("xori0", 32'h0030C013, 64'h1018, ALU_XOR,   64'd5, 64'd3, 5'd0, 1'b0, 1'b0);
    one("addw",  32'h0020833B, 64'h101C, ALU_ADDW,  64'd5, 64'd7, 5'd6, 1'b1, 1'b0);

    // Backpressure: three back-to-back offers while execute stalls.
    out_ready = 1'b0;
    offer(32'h002081B3, 64'h100);
    tick();
    chk("bp.1.pc", out_pc, 64'h100);
    chk("bp.1.in_ready", 64'(in_ready), 64'd1);
    offer(32'h40208233, 64'h104);
    tick();
    chk("bp.2.in_ready", 64'(in_ready), 64'd0);
    chk("bp.2.hold_pc", out_pc, 64'h100);
    chk("bp.2.hold_op", 64'(out_aluop), 64'(ALU_ADD));
    offer(32'h0020833B, 64'h108);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("bp.stall.pc", out_pc, 64'h100);
      chk("bp.stall.in_ready", 64'(in_ready), 64'd0);
      chk("bp.stall.valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp.out2.pc", out_pc, 64'h104);
    chk("bp.out2.op", 64'(out_aluop), 64'(ALU_SUB));
    chk("bp.out2.in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.out3.pc", out_pc, 64'h108);
    chk("bp.out3.op", 64'(out_aluop), 64'(ALU_ADDW));
    tick();
    chk("bp.empty", 64'(out_valid), 64'd0);

    // Flush with both entries full.
    out_ready = 1'b0;
    offer(32'h002081B3, 64'h200);
    tick();
    offer(32'h002081B3, 64'h204);
    tick();
    chk("fl.full", 64'(in_ready), 64'd0);
    offer(32'h002081B3, 64'h208);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl.valid", 64'(out_valid), 64'd0);
    chk("fl.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("fl.stays_empty", 64'(out_valid), 64'd0);

    // Flush wins over out_ready, and the accept in the flush cycle is dropped.
    offer(32'h002081B3, 64'h300);
    tick();
    chk("fl2.loaded", out_pc, 64'h300);
    offer(32'h002081B3, 64'h304);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2.valid", 64'(out_valid), 64'd0);
    tick();
    chk("fl2.no_ghost", 64'(out_valid), 64'd0);

    // Async reset mid-stream with both entries full.
    out_ready = 1'b0;
    offer(32'h002081B3, 64'h400);
    tick();
    offer(32'h002081B3, 64'h404);
    tick();
    in_valid = 1'b0;
    chk("ar.full", 64'(in_ready), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("ar.valid", 64'(out_valid), 64'd0);
    chk("ar.in_ready", 64'(in_ready), 64'd1);
    chk("ar.pc", out_pc, 64'd0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("ar.post_empty", 64'(out_valid), 64'd0);
    one("ar.first", 32'h40208233, 64'h500, ALU_SUB, 64'd5, 64'd7, 5'd4, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
